// File: rtl/drive_pkg.sv
// drive_pkg: mode constants, drive state encoding and sensor/state decode helpers
// Ports: none (package shared by sense_debounce and drive_ctrl)
package drive_pkg;
  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_FWD   = 2'b11;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD    = 3'd1,
    LEFT   = 3'd2,
    RIGHT  = 3'd3,
    SEARCH = 3'd4,
    HALT   = 3'd5,
    LOST   = 3'd6
  } state_t;
  function automatic state_t decode(input logic [2:0] s);
    return (s == 3'b000) ? SEARCH :
           (s == 3'b100 || s == 3'b110) ? LEFT :
           (s == 3'b001 || s == 3'b011) ? RIGHT : FWD;
  endfunction
  function automatic logic [1:0] mode_of(input state_t st, input logic dir_left);
    return st == FWD   ? MODE_FWD :
           st == LEFT  ? MODE_LEFT :
           st == RIGHT ? MODE_RIGHT :
           st == SEARCH ? (dir_left ? MODE_LEFT : MODE_RIGHT) : MODE_STOP;
  endfunction
endpackage

// File: rtl/sense_debounce.sv
// sense_debounce: 2-flop synchroniser plus stable-count debounce for a WIDTH-bit bus
// Ports: clk, rst (sync active-low), raw (async input), db (debounced output)
module sense_debounce import drive_pkg::*; #(
  parameter int WIDTH = 3,
  parameter int CYC   = 100_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] db
);
  localparam logic [31:0] LIM = 32'(CYC - 1);
  logic [WIDTH-1:0] s1, s2, prev;
  logic [31:0] cnt;
  // cnt holds how many consecutive cycles s2 has shown the same non-accepted value
  always_ff @(posedge clk)
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      db   <= '0;
      cnt  <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= s2;
      if (s2 == db) cnt <= '0;
      else if (s2 != prev) cnt <= 32'd1;
      else if (cnt >= LIM) begin
        db  <= s2;
        cnt <= '0;
      end else cnt <= cnt + 32'd1;
    end
endmodule

// File: rtl/drive_ctrl.sv
// drive_ctrl: line-following drive FSM producing the 2-bit motor mode word
// Ports: clk, rst (sync active-low), sensor {l,c,r}, obstacle, start, stop -> mode, state_o, lost
module drive_ctrl import drive_pkg::*; #(
  parameter int DEBOUNCE_CYC = 100_000,
  parameter int HOLD_CYC     = 500_000,
  parameter int LOST_CYC     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sensor,
  input  logic       obstacle,
  input  logic       start,
  input  logic       stop,
  output logic [1:0] mode,
  output logic [2:0] state_o,
  output logic       lost
);
  localparam logic [31:0] HOLD     = 32'(HOLD_CYC);
  localparam logic [31:0] LOST_SAT = 32'(LOST_CYC);
  localparam logic [31:0] LOST_LIM = 32'(LOST_CYC - 1);
  state_t state, nxt, tgt;
  logic ob1, ob2, dir_left;
  logic [2:0] s_db;
  logic [31:0] hold_cnt, lost_cnt;
  sense_debounce #(.WIDTH(3), .CYC(DEBOUNCE_CYC)) u_db (
    .clk(clk),
    .rst(rst),
    .raw(sensor),
    .db (s_db)
  );
  assign tgt = decode(s_db);
  always_comb begin
    nxt = state;
    if (stop) nxt = IDLE;
    else if (ob2 && (state inside {FWD, LEFT, RIGHT, SEARCH})) nxt = HALT;
    else
      case (state)
        IDLE, LOST:       nxt = start ? tgt : state;
        FWD, LEFT, RIGHT: nxt = (tgt != state && hold_cnt >= HOLD) ? tgt : state;
        SEARCH:           nxt = (s_db != 3'b000) ? tgt : (lost_cnt >= LOST_LIM) ? LOST : SEARCH;
        HALT:             nxt = ob2 ? HALT : tgt;
        default:          nxt = IDLE;
      endcase
  end
  // outputs are decoded from nxt so they register on the same edge as state
  always_ff @(posedge clk)
    if (!rst) begin
      ob1      <= 1'b0;
      ob2      <= 1'b0;
      state    <= IDLE;
      dir_left <= 1'b1;
      hold_cnt <= '0;
      lost_cnt <= '0;
      mode     <= MODE_STOP;
      state_o  <= 3'd0;
      lost     <= 1'b0;
    end else begin
      ob1      <= obstacle;
      ob2      <= ob1;
      state    <= nxt;
      hold_cnt <= (nxt != state) ? '0 : (hold_cnt >= HOLD) ? hold_cnt : hold_cnt + 32'd1;
      lost_cnt <= (nxt != state) ? '0 : (lost_cnt >= LOST_SAT) ? lost_cnt : lost_cnt + 32'd1;
      if (nxt != state && (nxt == LEFT || nxt == RIGHT)) dir_left <= (nxt == LEFT);
      mode     <= mode_of(nxt, dir_left);
      state_o  <= nxt;
      lost     <= (nxt == LOST);
    end
endmodule

// File: tb/tb_drive_ctrl.sv
// tb_drive_ctrl: scoreboard bench for drive_ctrl with short debounce/hold/lost timings
module tb_drive_ctrl;
  logic clk = 1'b0, rst = 1'b0, obstacle = 1'b0, start = 1'b0, stop = 1'b0;
  logic [2:0] sensor = 3'b000;
  logic [1:0] mode;
  logic [2:0] state_o;
  logic lost;
  int cyc = 0, checks = 0, fails = 0;
  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [2:0] st;
    logic       lost;
    string      name;
  } exp_t;
  exp_t q[$];
  drive_ctrl #(.DEBOUNCE_CYC(4), .HOLD_CYC(8), .LOST_CYC(20)) dut (
    .clk     (clk),
    .rst     (rst),
    .sensor  (sensor),
    .obstacle(obstacle),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .state_o (state_o),
    .lost    (lost)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        fails++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if ({mode, state_o, lost} !== {e.mode, e.st, e.lost}) begin
        fails++;
        $display("FAIL %s @%0d: got mode=%b state=%0d lost=%b, want mode=%b state=%0d lost=%b",
                 e.name, cyc, mode, state_o, lost, e.mode, e.st, e.lost);
      end
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input int d, input logic [1:0] m, input logic [2:0] s, input logic l, input string nm);
    exp_t e;
    e = '{cyc + d, m, s, l, nm};
    q.push_back(e);
  endtask
  initial begin
    tick(2);
    chk(0, 2'b00, 3'd0, 1'b0, "reset");
    rst = 1'b1;
    sensor = 3'b010;
    tick(8);
    chk(0, 2'b00, 3'd0, 1'b0, "idle_before_start");
    start = 1'b1; tick(1); start = 1'b0;
    chk(0, 2'b11, 3'd1, 1'b0, "start_fwd");
    tick(10);
    sensor = 3'b110; tick(3); sensor = 3'b010;
    chk(6, 2'b11, 3'd1, 1'b0, "glitch_ignored");
    tick(8);
    sensor = 3'b110;
    chk(6, 2'b11, 3'd1, 1'b0, "left_not_yet");
    chk(7, 2'b10, 3'd2, 1'b0, "left_at_k7");
    tick(8);
    sensor = 3'b010;
    chk(7, 2'b10, 3'd2, 1'b0, "hold_blocks");
    chk(8, 2'b11, 3'd1, 1'b0, "hold_release");
    tick(10);
    obstacle = 1'b1;
    chk(2, 2'b11, 3'd1, 1'b0, "obs_not_yet");
    chk(3, 2'b00, 3'd5, 1'b0, "obs_halt");
    tick(5);
    obstacle = 1'b0;
    chk(2, 2'b00, 3'd5, 1'b0, "halt_hold");
    chk(3, 2'b11, 3'd1, 1'b0, "obs_release");
    tick(10);
    sensor = 3'b110;
    chk(7, 2'b10, 3'd2, 1'b0, "to_left");
    tick(18);
    sensor = 3'b000;
    chk(7, 2'b10, 3'd4, 1'b0, "search_dir_left");
    chk(17, 2'b10, 3'd4, 1'b0, "searching");
    chk(29, 2'b00, 3'd6, 1'b1, "lost");
    tick(30);
    sensor = 3'b010;
    tick(8);
    chk(0, 2'b00, 3'd6, 1'b1, "lost_wait_start");
    start = 1'b1; tick(1); start = 1'b0;
    chk(0, 2'b11, 3'd1, 1'b0, "restart_fwd");
    tick(10);
    sensor = 3'b011;
    chk(7, 2'b01, 3'd3, 1'b0, "to_right");
    tick(18);
    sensor = 3'b000;
    chk(7, 2'b01, 3'd4, 1'b0, "search_right");
    tick(9);
    rst = 1'b0; tick(1); rst = 1'b1;
    chk(0, 2'b00, 3'd0, 1'b0, "reset_mid_search");
    start = 1'b1; tick(1); start = 1'b0;
    chk(0, 2'b10, 3'd4, 1'b0, "last_dir_reset");
    sensor = 3'b001;
    chk(7, 2'b01, 3'd3, 1'b0, "search_exit");
    tick(8);
    stop = 1'b1; tick(1); stop = 1'b0;
    chk(0, 2'b00, 3'd0, 1'b0, "stop");
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    chk(0, 2'b00, 3'd0, 1'b0, "start_stop");
    tick(3);
    chk(0, 2'b00, 3'd0, 1'b0, "still_idle");
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      fails++;
      $display("FAIL %s: cycle %0d never reached", e.name, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
